generic_hw_snap_regs: RTL
=========================

GENERIC_HW_SNAP_REGS -- requirements
Module: generic_hw_snap_regs

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2: width of the request source ID.
REQ-002 SHALL have parameter TAG, default 0: block tag compared against addr[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH].
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5: width of the in-block word address.
REQ-004 SHALL have parameter NUM_REGS_USED, default 8: number of hardware registers.
REQ-005 SHALL have parameter HW_REG_WIDTH, default 64: width of each hardware register, 1..256.
REQ-006 SHALL have parameter REG_START_ADDR, default 0: first in-block word address.
REQ-007 SHALL have derived constant WORDS = ceil(HW_REG_WIDTH/`CPCI_NF2_DATA_WIDTH): words per register.
REQ-008 SHALL have ports: clk, in, 1, clock; reset, in, 1, synchronous active-high reset.
REQ-009 SHALL have input ports reg_req_in, reg_ack_in, reg_rd_wr_L_in (1 each), reg_addr_in (`UDP_REG_ADDR_WIDTH), reg_data_in (`CPCI_NF2_DATA_WIDTH), reg_src_in (UDP_REG_SRC_WIDTH): upstream register chain.
REQ-010 SHALL have registered output ports reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out, with widths matching the inputs: downstream register chain.
REQ-011 SHALL have input port hardware_regs, NUM_REGS_USED*HW_REG_WIDTH bits: live register values; register k occupies [HW_REG_WIDTH*(k+1)-1 : HW_REG_WIDTH*k].

Function
REQ-012 SHALL map word w of register k to in-block address A = REG_START_ADDR + k*WORDS + w; word 0 is least significant.
REQ-013 SHALL define hit = reg_req_in & !reg_ack_in & tag match & REG_START_ADDR <= addr < REG_START_ADDR + NUM_REGS_USED*WORDS.
REQ-014 SHALL, when there is no hit, copy every chain input to the matching output one cycle later, unchanged.
REQ-015 SHALL, on a hit, drive reg_ack_out=1 one cycle later and copy req, rd_wr_L, addr and src through.
REQ-016 SHALL, on a read hit of word 0 of register k, return live bits [31:0] and load shadow[k] with the whole live register value in that same cycle.
REQ-017 SHALL, on a read hit of word w>0, return shadow[k] word w, making multi-word reads atomic.
REQ-018 SHALL zero-pad the bits of the top word that lie above HW_REG_WIDTH.
REQ-019 SHALL, on a write hit, ack with reg_data_out=reg_data_in and leave the shadows unchanged; the registers are read-only.
REQ-020 SHALL keep one shadow per register, so interleaved reads of different registers stay independent.
REQ-021 SHALL, when reading word w>0 before any word-0 read since reset, return 0.
REQ-022 SHALL ignore a request with reg_ack_in=1 already set (passed through per REQ-014), even when it is in range.
REQ-023 SHALL accept back-to-back requests every cycle; throughput 1/cycle; latency exactly 1 cycle.

Reset
REQ-024 SHALL, while reset=1, drive all chain outputs to 0 on the next clk edge and clear all shadows to 0.
REQ-025 SHALL drop a request present in the reset cycle; no ack is produced and no shadow is loaded.

Configuration
REQ-026 SHALL, when macro GENERIC_HW_SNAP_REGS_CLR_ON_READ_EN is defined, add output hw_reg_clear[NUM_REGS_USED-1:0].
REQ-027 SHALL, with that macro defined, pulse hw_reg_clear[k] high for exactly one cycle, aligned with reg_ack_out, on each word-0 read hit of register k; it is 0 in reset.
REQ-028 SHALL, without that macro, have no hw_reg_clear port, and reads SHALL have no side effect on the hardware.

Verification
REQ-029 Bench SHALL cover: HW_REG_WIDTH=64, TAG=0, reg1=0x11112222_33334444; read addr 2 then addr 3 -> data 0x33334444 then 0x11112222, ack=1 each.
REQ-030 Bench SHALL cover: read addr 2 (reg1=0x0000_0005_0000_0001), change reg1 to 0x0000_0009_0000_0001, read addr 3 -> 0x00000005 (shadow, not live).
REQ-031 Bench SHALL cover: request to addr 16 (beyond 8*2 words) or with a tag mismatch -> outputs equal inputs delayed 1 cycle, ack=0.
REQ-032 Bench SHALL cover: an in-range read with reg_ack_in=1 and data 0xDEADBEEF -> data 0xDEADBEEF passed through, shadow unchanged.
REQ-033 Bench SHALL cover: HW_REG_WIDTH=40, reg0=0xAB_CDEF0123; read addr 0 then addr 1 -> 0xCDEF0123 then 0x000000AB.
REQ-034 Bench SHALL cover: with the macro defined, a read of addr 4 -> hw_reg_clear=8'h04 for one cycle coincident with ack; a read of addr 5 -> no pulse; reset asserted mid-stream -> all outputs 0 and shadows 0.

Source files
------------

// File: rtl/generic_hw_snap_regs.sv
// rtl/generic_hw_snap_regs.sv - read-only hardware register block with atomic multi-word snapshots
//
// Sits in a daisy-chained register bus. Requests addressed to this block
// (tag match, in-block address inside the register window, not already
// acked) are answered one cycle later; all other traffic passes through
// with one cycle of delay.
//
// Each hardware register of HW_REG_WIDTH bits is presented as WORDS
// consecutive bus words, least significant word first. Reading word 0
// returns the live low word and captures the entire live register into a
// per-register shadow; the higher words are then served from that shadow,
// so a word-0-first read sequence always sees one coherent value.
//
// Optional feature macro: GENERIC_HW_SNAP_REGS_CLR_ON_READ_EN
//   When defined, adds hw_reg_clear, a one-cycle pulse per register aligned
//   with the ack of each word-0 read, so the owner can clear-on-read.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   reg_req_in        - upstream request valid
//   reg_ack_in        - upstream ack (request already served)
//   reg_rd_wr_L_in    - 1 = read, 0 = write
//   reg_addr_in       - bus word address (tag in the upper bits)
//   reg_data_in       - write data / data passing along the chain
//   reg_src_in        - requester ID
//   reg_*_out         - registered downstream copies of the above
//   hardware_regs     - live register values, register k at slice k
//   hw_reg_clear      - (macro only) word-0 read pulse per register

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module generic_hw_snap_regs #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_REGS_USED     = 8,
  parameter int HW_REG_WIDTH      = 64,
  parameter int REG_START_ADDR    = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic                                  reg_req_in,
  input  logic                                  reg_ack_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_in,

  output logic                                  reg_req_out,
  output logic                                  reg_ack_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]       reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_out,

  input  logic [NUM_REGS_USED*HW_REG_WIDTH-1:0] hardware_regs
`ifdef GENERIC_HW_SNAP_REGS_CLR_ON_READ_EN
  ,
  output logic [NUM_REGS_USED-1:0]              hw_reg_clear
`endif
);

  localparam int DATA_W = `CPCI_NF2_DATA_WIDTH;
  localparam int ADDR_W = `UDP_REG_ADDR_WIDTH;
  localparam int TAG_W  = ADDR_W - REG_ADDR_WIDTH;
  localparam int WORDS  = (HW_REG_WIDTH + DATA_W - 1) / DATA_W;
  localparam int PAD_W  = WORDS * DATA_W;

  localparam logic [TAG_W-1:0] TAG_VAL    = TAG_W'(TAG);
  localparam logic [31:0]      WIN_START  = 32'(REG_START_ADDR);
  localparam logic [31:0]      WIN_END    = 32'(REG_START_ADDR + NUM_REGS_USED * WORDS);

  // Live registers zero-extended to a whole number of bus words, so the
  // top word of a register narrower than PAD_W reads with zero padding.
  logic [PAD_W-1:0] live_pad [NUM_REGS_USED];

  for (genvar g = 0; g < NUM_REGS_USED; g++) begin : g_live
    assign live_pad[g] = PAD_W'(hardware_regs[HW_REG_WIDTH*g +: HW_REG_WIDTH]);
  end

  logic [PAD_W-1:0] shadow [NUM_REGS_USED];

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [31:0]              blk_addr;
  logic [31:0]              offset;
  logic                     tag_match;
  logic                     in_range;
  logic                     hit;
  logic                     rd_hit;
  logic [DATA_W-1:0]        rd_word;
  logic [NUM_REGS_USED-1:0] word0_sel;
  logic [NUM_REGS_USED-1:0] word0_rd;

  assign blk_addr  = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]);
  assign offset    = blk_addr - WIN_START;
  assign tag_match = (reg_addr_in[ADDR_W-1:REG_ADDR_WIDTH] == TAG_VAL);
  assign in_range  = (blk_addr >= WIN_START) && (blk_addr < WIN_END);
  assign hit       = reg_req_in && !reg_ack_in && tag_match && in_range;
  assign rd_hit    = hit && reg_rd_wr_L_in;
  assign word0_rd  = word0_sel & {NUM_REGS_USED{rd_hit}};

  // Word select. Offsets outside the window (including the wrap-around of
  // addresses below the window start) match no slot and leave rd_word 0,
  // but hit is already low for them so the value is never used.
  always_comb begin
    rd_word   = '0;
    word0_sel = '0;
    for (int k = 0; k < NUM_REGS_USED; k++) begin
      for (int w = 0; w < WORDS; w++) begin
        if (offset == 32'(k * WORDS + w)) begin
          if (w == 0) begin
            rd_word      = live_pad[k][DATA_W-1:0];
            word0_sel[k] = 1'b1;
          end else begin
            rd_word = shadow[k][w*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Chain output stage and shadow capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      for (int k = 0; k < NUM_REGS_USED; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      reg_ack_out     <= hit ? 1'b1 : reg_ack_in;
      // Writes to this block are acked but the data passes unchanged.
      reg_data_out    <= rd_hit ? rd_word : reg_data_in;
      for (int k = 0; k < NUM_REGS_USED; k++) begin
        if (word0_rd[k]) begin
          shadow[k] <= live_pad[k];
        end
      end
    end
  end

`ifdef GENERIC_HW_SNAP_REGS_CLR_ON_READ_EN
  // Registered alongside reg_ack_out so the pulse lines up with the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_reg_clear <= '0;
    end else begin
      hw_reg_clear <= word0_rd;
    end
  end
`else
  // Reads have no side effect on the hardware; word-0 strobes only load
  // the shadows.
`endif

endmodule
